// File: rtl/fm_seq_pkg.sv
// Shared types and defaults for the fundamental-mode input sequencer.
package fm_seq_pkg;

  // Sequencer FSM states
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_D = 4;
  localparam int unsigned SETTLE_CYCLES_D   = 8;

endpackage : fm_seq_pkg

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a run-length debounce filter.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   raw  : asynchronous raw input
//   filt : debounced value, updates after DEBOUNCE_CYCLES consecutive differing cycles
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Filter: any cycle where s2 matches filt restarts the run count
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (s2 != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule : input_debouncer

// File: rtl/fm_input_sequencer.sv
// Conditions two raw async inputs for a fundamental-mode machine: debounces them,
// then releases at most one output change at a time with a settle window after each.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   raw_x1/raw_x2 : asynchronous raw inputs
//   X1/X2         : registered sequenced outputs
//   change_strobe : one-cycle pulse after an output change
//   busy          : high during the settle window
module fm_input_sequencer
  import fm_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_D,
  parameter int unsigned SETTLE_CYCLES   = SETTLE_CYCLES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_x1,
  input  logic raw_x2,
  output logic X1,
  output logic X2,
  output logic change_strobe,
  output logic busy
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SCNT_LOAD = SW'(SETTLE_CYCLES - 1);

  logic          f1;
  logic          f2;
  state_t        state;
  state_t        state_d;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_d;
  logic          x1_d;
  logic          x2_d;
  logic          strobe_d;
  logic          busy_d;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_x1 (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_x1),
    .filt (f1)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_x2 (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_x2),
    .filt (f2)
  );

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      scnt          <= '0;
      X1            <= 1'b0;
      X2            <= 1'b0;
      change_strobe <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      scnt          <= scnt_d;
      X1            <= x1_d;
      X2            <= x2_d;
      change_strobe <= strobe_d;
      busy          <= busy_d;
    end
  end

  // Next state: one output change per edge, X1 wins ties
  always_comb begin
    state_d  = state;
    scnt_d   = scnt;
    x1_d     = X1;
    x2_d     = X2;
    strobe_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (f1 != X1) begin
          x1_d     = f1;
          strobe_d = 1'b1;
          scnt_d   = SCNT_LOAD;
          state_d  = SETTLE;
        end else if (f2 != X2) begin
          x2_d     = f2;
          strobe_d = 1'b1;
          scnt_d   = SCNT_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (scnt == '0) begin
          state_d = IDLE;
        end else begin
          scnt_d = scnt - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Busy also covers the exit edge, so it spans edges e..e+SETTLE_CYCLES
    busy_d = (state_d == SETTLE) || (state == SETTLE);
  end

endmodule : fm_input_sequencer

// File: tb/tb_fm_input_sequencer.sv
// Directed bench for fm_input_sequencer at default parameters.
module tb_fm_input_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic raw_x1;
  logic raw_x2;
  logic X1;
  logic X2;
  logic change_strobe;
  logic busy;

  int total = 0;
  int bad   = 0;

  localparam int S_RISE    = 0;
  localparam int S_GLITCH  = 1;
  localparam int S_SIMUL   = 2;
  localparam int S_NETZERO = 3;
  localparam int S_RSTMID  = 4;

  fm_input_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .raw_x1        (raw_x1),
    .raw_x2        (raw_x2),
    .X1            (X1),
    .X2            (X2),
    .change_strobe (change_strobe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  // Three reset edges with the given raw levels; outputs must stay cleared
  task automatic do_reset(input logic r1, input logic r2);
    rst    = 1'b1;
    raw_x1 = r1;
    raw_x2 = r2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d X1", i), X1, 1'b0);
      check($sformatf("rst%0d X2", i), X2, 1'b0);
      check($sformatf("rst%0d strobe", i), change_strobe, 1'b0);
      check($sformatf("rst%0d busy", i), busy, 1'b0);
    end
    rst    = 1'b0;
    raw_x1 = 1'b0;
    raw_x2 = 1'b0;
  endtask

  // Edge k is the k-th rising edge after the scenario's initial raw levels are applied
  task automatic run_scen(input int scen, input int n);
    logic ex1, ex2, estb, ebsy;
    case (scen)
      S_RISE:    begin raw_x1 = 1'b1; raw_x2 = 1'b0; end
      S_GLITCH:  begin raw_x1 = 1'b1; raw_x2 = 1'b0; end
      S_SIMUL:   begin raw_x1 = 1'b1; raw_x2 = 1'b1; end
      S_NETZERO: begin raw_x1 = 1'b1; raw_x2 = 1'b1; end
      default:   begin raw_x1 = 1'b1; raw_x2 = 1'b0; end
    endcase
    for (int k = 0; k < n; k++) begin
      if (scen == S_GLITCH  && k == 3)  raw_x1 = 1'b0;
      if (scen == S_NETZERO && k == 5)  raw_x2 = 1'b0;
      if (scen == S_RSTMID  && k == 9)  rst = 1'b1;
      if (scen == S_RSTMID  && k == 10) rst = 1'b0;
      @(posedge clk);
      #1;
      case (scen)
        S_RISE, S_NETZERO: begin
          ex1 = (k >= 6); ex2 = 1'b0;
          estb = (k == 6); ebsy = (k >= 6 && k <= 14);
        end
        S_GLITCH: begin
          ex1 = 1'b0; ex2 = 1'b0; estb = 1'b0; ebsy = 1'b0;
        end
        S_SIMUL: begin
          ex1 = (k >= 6); ex2 = (k >= 15);
          estb = (k == 6) || (k == 15); ebsy = (k >= 6 && k <= 23);
        end
        default: begin
          ex1 = (k >= 6 && k < 9) || (k >= 16); ex2 = 1'b0;
          estb = (k == 6) || (k == 16);
          ebsy = (k >= 6 && k <= 8) || (k >= 16 && k <= 24);
        end
      endcase
      check($sformatf("s%0d e%0d X1", scen, k), X1, ex1);
      check($sformatf("s%0d e%0d X2", scen, k), X2, ex2);
      check($sformatf("s%0d e%0d strobe", scen, k), change_strobe, estb);
      check($sformatf("s%0d e%0d busy", scen, k), busy, ebsy);
    end
  endtask

  initial begin
    rst    = 1'b1;
    raw_x1 = 1'b0;
    raw_x2 = 1'b0;
    @(negedge clk);
    do_reset(1'b1, 1'b1);
    do_reset(1'b0, 1'b0);
    run_scen(S_RISE, 20);
    do_reset(1'b0, 1'b0);
    run_scen(S_GLITCH, 16);
    do_reset(1'b0, 1'b0);
    run_scen(S_SIMUL, 28);
    do_reset(1'b0, 1'b0);
    run_scen(S_NETZERO, 22);
    do_reset(1'b0, 1'b0);
    run_scen(S_RSTMID, 28);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fm_input_sequencer
